// File: rtl/sm_uart_tx_pkg.sv
// sm_uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter: register
// offsets (addr[3:2]), STATUS bit positions, FSM state encoding and a
// helper that turns a DIVISOR value into a bit length in cycles.
// No ports.
package sm_uart_tx_pkg;

    // Register offsets, selected by addr[3:2]
    localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
    localparam logic [1:0] UART_REG_STATUS  = 2'd1;
    localparam logic [1:0] UART_REG_DIVISOR = 2'd2;
    localparam logic [1:0] UART_REG_CTRL    = 2'd3;

    // STATUS bit positions
    localparam int UART_ST_BUSY    = 0;
    localparam int UART_ST_FULL    = 1;
    localparam int UART_ST_EMPTY   = 2;
    localparam int UART_ST_OVF     = 3;
    localparam int UART_ST_CNT_LSB = 8;

    // Transmit FSM states
    typedef enum logic [1:0] {
        UART_S_IDLE  = 2'd0,
        UART_S_START = 2'd1,
        UART_S_DATA  = 2'd2,
        UART_S_STOP  = 2'd3
    } uart_state_e;

    // A divisor of zero would give a zero-length bit; treat it as one cycle.
    function automatic logic [15:0] bit_cycles(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/sm_fifo_sync.sv
// sm_fifo_sync
// Single-clock FIFO with show-ahead head data, so a consumer can take the
// head word in the same cycle it pops.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (flushes pointers)
//   push, push_data     write request; accepted when not full or when a pop
//                       happens in the same cycle
//   pop, pop_data       read request (ignored when empty); pop_data = head
//   full, empty, count  occupancy flags and entry count
module sm_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_do;
    logic             pop_do;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_do   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still fits.
    assign push_do  = push & (~full | pop_do);
    // Head is read asynchronously so the pop and the data capture coincide.
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_do) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_do) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_do) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_do, pop_do})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sm_uart_tx.sv
// sm_uart_tx
// Memory-mapped 8N1 UART transmitter (LSB first) with a byte FIFO.
// Registers (addr[3:2]): 0 TXDATA (write pushes), 1 STATUS, 2 DIVISOR, 3 CTRL.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sel          address decode hit; qualifies we and gates rdata
//   addr         byte address, only addr[3:2] decoded
//   we, wdata    write strobe and data
//   rdata        combinational read data (0 when sel=0)
//   tx           serial output, idle high
//   irq          only when SM_UART_TX_IRQ_EN is defined: registered
//                irq_en & empty & ~busy
// Optional feature macro: SM_UART_TX_IRQ_EN (adds irq port and CTRL bit1).
module sm_uart_tx
    import sm_uart_tx_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
`ifdef SM_UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    reg_idx;
    logic          wr_en;
    logic          push_req;
    logic          pop;
    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          busy;
    logic          unused_bits;

    logic [15:0]   div_reg;
    logic          enable_reg;
    logic          overflow_reg;
`ifdef SM_UART_TX_IRQ_EN
    logic          irq_en_reg;
    logic          irq_reg;
`endif

    uart_state_e   state_reg, state_next;
    logic [15:0]   baud_cnt_reg, baud_cnt_next;
    logic [15:0]   bit_len_reg, bit_len_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          tx_reg, tx_next;

    assign reg_idx     = addr[3:2];
    assign wr_en       = sel & we;
    assign push_req    = wr_en && (reg_idx == UART_REG_TXDATA);
    assign busy        = (state_reg != UART_S_IDLE);
    assign tx          = tx_reg;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};

    sm_fifo_sync #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (wdata[7:0]),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Control/status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg      <= DIV_RESET;
            enable_reg   <= 1'b0;
            overflow_reg <= 1'b0;
`ifdef SM_UART_TX_IRQ_EN
            irq_en_reg   <= 1'b0;
`endif
        end else begin
            if (wr_en && reg_idx == UART_REG_DIVISOR) begin
                div_reg <= wdata[15:0];
            end
            if (wr_en && reg_idx == UART_REG_CTRL) begin
                enable_reg <= wdata[0];
`ifdef SM_UART_TX_IRQ_EN
                irq_en_reg <= wdata[1];
`endif
            end
            // Pushes and STATUS writes target different offsets, never both.
            if (push_req && full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (wr_en && reg_idx == UART_REG_STATUS && wdata[UART_ST_OVF]) begin
                overflow_reg <= 1'b0;
            end
        end
    end

`ifdef SM_UART_TX_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_en_reg & empty & ~busy;
        end
    end
    assign irq = irq_reg;
`endif

    // Transmit FSM state register; tx resets high so the line idles at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= UART_S_IDLE;
            baud_cnt_reg <= '0;
            bit_len_reg  <= 16'd1;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_len_reg  <= bit_len_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
        end
    end

    // Next-state logic. tx is registered, so each branch sets the line level
    // that the following bit period will show.
    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_len_next  = bit_len_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        pop           = 1'b0;
        unique case (state_reg)
            UART_S_IDLE: begin
                tx_next = 1'b1;
                if (enable_reg && !empty) begin
                    pop           = 1'b1;
                    shift_next    = head;
                    // The divisor is frozen for the whole frame here.
                    bit_len_next  = bit_cycles(div_reg);
                    baud_cnt_next = bit_cycles(div_reg) - 16'd1;
                    state_next    = UART_S_START;
                    tx_next       = 1'b0;
                end
            end
            UART_S_START: begin
                if (baud_cnt_reg == '0) begin
                    baud_cnt_next = bit_len_reg - 16'd1;
                    bit_idx_next  = '0;
                    state_next    = UART_S_DATA;
                    tx_next       = shift_reg[0];
                end else begin
                    baud_cnt_next = baud_cnt_reg - 16'd1;
                end
            end
            UART_S_DATA: begin
                if (baud_cnt_reg == '0) begin
                    baud_cnt_next = bit_len_reg - 16'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = UART_S_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        shift_next   = {1'b0, shift_reg[7:1]};
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    baud_cnt_next = baud_cnt_reg - 16'd1;
                end
            end
            UART_S_STOP: begin
                if (baud_cnt_reg == '0) begin
                    state_next = UART_S_IDLE;
                    tx_next    = 1'b1;
                end else begin
                    baud_cnt_next = baud_cnt_reg - 16'd1;
                end
            end
            default: begin
                state_next = UART_S_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    // Read mux
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_idx)
                UART_REG_STATUS: begin
                    rdata[UART_ST_BUSY]                    = busy;
                    rdata[UART_ST_FULL]                    = full;
                    rdata[UART_ST_EMPTY]                   = empty;
                    rdata[UART_ST_OVF]                     = overflow_reg;
                    rdata[UART_ST_CNT_LSB +: 8]            = 8'(count);
                end
                UART_REG_DIVISOR: rdata[15:0] = div_reg;
                UART_REG_CTRL: begin
                    rdata[0] = enable_reg;
`ifdef SM_UART_TX_IRQ_EN
                    rdata[1] = irq_en_reg;
`endif
                end
                default: rdata = '0;
            endcase
        end
    end

endmodule
